axi4_lite_initiator: RTL and testbench

Single-transaction AXI4-Lite master. It converts a one-cycle command strobe from local control logic into a complete AXI4-Lite write (AW/W/B) or read (AR/R). It then returns the response code and any read data. It drives the S_AXI port of register-mapped blocks such as the interrupt timer, so firmware-free logic and benches can program and read them.

---
 rtl/axi4_lite_initiator.sv | 131 +++++++++++++
 tb/tb_axi4_lite_initiator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_initiator.sv
// axi4_lite_initiator: single-transaction AXI4-Lite master; cmd_* is the local command/status side, M_AXI_* is the AXI4-Lite master port
module axi4_lite_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  cmd_idle,
  output logic                  cmd_done,
  output logic [1:0]            cmd_resp,
  output logic [DATA_WIDTH-1:0] cmd_rdata,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  output logic [2:0]            M_AXI_AWPROT,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            resp_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  done_q;
  logic                  idle_q;
  logic                  aw_ok;
  logic                  w_ok;
  // a channel is finished once its VALID has dropped, or it handshakes this cycle
  assign aw_ok         = !awvalid_q || M_AXI_AWREADY;
  assign w_ok          = !wvalid_q || M_AXI_WREADY;
  assign cmd_idle      = idle_q;
  assign cmd_done      = done_q;
  assign cmd_resp      = resp_q;
  assign cmd_rdata     = rdata_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_start) begin
          addr_q    <= cmd_addr;
          wdata_q   <= cmd_wdata;
          wstrb_q   <= cmd_wstrb;
          idle_q    <= 1'b0;
          state_q   <= cmd_write ? WR_ADDR_DATA : RD_ADDR;
          awvalid_q <= cmd_write;
          wvalid_q  <= cmd_write;
          arvalid_q <= !cmd_write;
        end
        WR_ADDR_DATA: begin
          awvalid_q <= awvalid_q && !M_AXI_AWREADY;
          wvalid_q  <= wvalid_q && !M_AXI_WREADY;
          if (aw_ok && w_ok) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
          end
        end
        WR_RESP: if (M_AXI_BVALID) begin
          state_q  <= IDLE;
          bready_q <= 1'b0;
          done_q   <= 1'b1;
          idle_q   <= 1'b1;
          resp_q   <= M_AXI_BRESP;
        end
        RD_ADDR: if (M_AXI_ARREADY) begin
          state_q   <= RD_DATA;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        RD_DATA: if (M_AXI_RVALID) begin
          state_q  <= IDLE;
          rready_q <= 1'b0;
          done_q   <= 1'b1;
          idle_q   <= 1'b1;
          resp_q   <= M_AXI_RRESP;
          rdata_q  <= M_AXI_RDATA;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_lite_initiator.sv
// tb_axi4_lite_initiator: randomized bench with a delay-programmable AXI4-Lite slave and a memory reference model
module tb_axi4_lite_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_idle, cmd_done;
  logic [1:0]  cmd_resp;
  logic [31:0] cmd_rdata;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [31:0] M_AXI_RDATA = '0;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0;
  logic        M_AXI_WREADY = 1'b0;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0;
  logic        M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0;
  logic [1:0]  M_AXI_RRESP = '0;
  int checks = 0;
  int failures = 0;
  // slave configuration, written by the stimulus only while no transaction is in flight
  int aw_left, w_left, b_left, ar_left, r_left;
  logic [1:0] b_resp_c, r_resp_c;
  // slave bookkeeping
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit aw_got, w_got, b_pend, b_hs, r_pend, r_hs;
  logic [31:0] aw_a, ar_a, w_dat;
  logic [3:0]  w_stb;
  logic [31:0] smem [int unsigned];
  // reference model
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_rd = '0;

  axi4_lite_initiator dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_idle(cmd_idle), .cmd_done(cmd_done),
    .cmd_resp(cmd_resp), .cmd_rdata(cmd_rdata),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  // Slave: decides READY/VALID on the falling edge, so every handshake it sees
  // here is the one the DUT samples on the following rising edge.
  always @(negedge clk) begin
    if (reset) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
      aw_got = 0; w_got = 0; b_pend = 0; b_hs = 0; r_pend = 0; r_hs = 0;
    end else begin
      if (b_hs) begin M_AXI_BVALID = 1'b0; b_pend = 0; end
      else if (b_pend) begin
        if (b_left > 0) b_left--;
        else begin M_AXI_BVALID = 1'b1; M_AXI_BRESP = b_resp_c; end
      end
      b_hs = M_AXI_BVALID && M_AXI_BREADY;
      if (b_hs) b_cnt++;
      if (r_hs) begin M_AXI_RVALID = 1'b0; r_pend = 0; end
      else if (r_pend) begin
        if (r_left > 0) r_left--;
        else begin M_AXI_RVALID = 1'b1; M_AXI_RRESP = r_resp_c; M_AXI_RDATA = smem_rd(ar_a); end
      end
      r_hs = M_AXI_RVALID && M_AXI_RREADY;
      if (r_hs) r_cnt++;
      M_AXI_AWREADY = M_AXI_AWVALID && aw_left == 0;
      if (M_AXI_AWVALID && aw_left > 0) aw_left--;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_cnt++; aw_a = M_AXI_AWADDR; aw_got = 1; end
      M_AXI_WREADY = M_AXI_WVALID && w_left == 0;
      if (M_AXI_WVALID && w_left > 0) w_left--;
      if (M_AXI_WVALID && M_AXI_WREADY) begin w_cnt++; w_dat = M_AXI_WDATA; w_stb = M_AXI_WSTRB; w_got = 1; end
      M_AXI_ARREADY = M_AXI_ARVALID && ar_left == 0;
      if (M_AXI_ARVALID && ar_left > 0) ar_left--;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin ar_cnt++; ar_a = M_AXI_ARADDR; r_pend = 1; end
      if (aw_got && w_got) begin
        smem[aw_a] = merge(smem_rd(aw_a), w_dat, w_stb);
        aw_got = 0; w_got = 0; b_pend = 1;
      end
    end
  end

  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int daw, input int dw, input int db, input int dar, input int dr,
                        input logic [1:0] rsp, input bit inject);
    int lat = 0;
    bit seen = 0;
    logic [31:0] exp_rd;
    int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, ar0 = ar_cnt, r0 = r_cnt;
    aw_left = daw; w_left = dw; b_left = db; ar_left = dar; r_left = dr;
    b_resp_c = rsp; r_resp_c = rsp;
    if (wr) begin
      ref_mem[a] = merge(ref_rd(a), d, s);
      exp_rd = last_rd;
    end else begin
      exp_rd = ref_rd(a);
      last_rd = exp_rd;
    end
    cmd_start = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      cmd_start = (lat == 1) && inject;
      if (lat == 1) begin
        cmd_write = !wr; cmd_addr = a ^ 32'h40; cmd_wdata = ~d;
        check("idle_busy", cmd_idle, 0);
        check("done_pulse", cmd_done, 0);
        check("awvalid_n1", M_AXI_AWVALID, wr);
        check("wvalid_n1", M_AXI_WVALID, wr);
        check("arvalid_n1", M_AXI_ARVALID, !wr);
        check("bready_n1", M_AXI_BREADY, 0);
        check("rready_n1", M_AXI_RREADY, 0);
      end
      if (lat == 2 && wr && dw == 0 && daw >= 2) begin
        check("wvalid_drop", M_AXI_WVALID, 0);
        check("awvalid_held", M_AXI_AWVALID, 1);
      end
      seen = cmd_done;
    end
    check("done_seen", seen, 1);
    check("idle_at_done", cmd_idle, 1);
    check("resp", cmd_resp, rsp);
    check("rdata", cmd_rdata, exp_rd);
    check("lat_min", lat >= 3, 1);
    if (wr ? (daw == 0 && dw == 0 && db == 0) : (dar == 0 && dr == 0)) check("lat_zero_wait", lat, 3);
    check("aw_hs", aw_cnt - aw0, wr);
    check("w_hs", w_cnt - w0, wr);
    check("b_hs", b_cnt - b0, wr);
    check("ar_hs", ar_cnt - ar0, !wr);
    check("r_hs", r_cnt - r0, !wr);
    if (wr) begin
      check("awaddr", aw_a, a);
      check("wdata", w_dat, d);
      check("wstrb", w_stb, s);
    end else check("araddr", ar_a, a);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", cmd_idle, 1);
    check("rst_done", cmd_done, 0);
    check("rst_resp", cmd_resp, 0);
    check("rst_rdata", cmd_rdata, 0);
    check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
    check("rst_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
    check("prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);
    do_cmd(1, 32'h4, 32'h5, 4'hF, 0, 0, 0, 0, 0, 2'd0, 0);
    do_cmd(1, 32'h4, 32'h5, 4'hF, 5, 0, 0, 0, 0, 2'd0, 0);
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 0, 3, 2'd0, 0);
    do_cmd(0, 32'h8, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd3, 0);
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, 0, 0, 2, 1, 2'd2, 1);
    do_cmd(1, 32'hC, 32'hA5A5_1234, 4'h5, 1, 3, 2, 0, 0, 2'd1, 1);
    // reset while waiting for B, then a normal write
    aw_left = 0; w_left = 0; b_left = 20; b_resp_c = 2'd0;
    ref_mem[32'h10] = merge(ref_rd(32'h10), 32'hDEAD_BEEF, 4'hF);
    cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (M_AXI_BREADY) break;
    end
    check("rst_mid_bready_seen", M_AXI_BREADY, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_bready", M_AXI_BREADY, 0);
    check("rst_mid_idle", cmd_idle, 1);
    check("rst_mid_done", cmd_done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_done2", cmd_done, 0);
    last_rd = '0;
    do_cmd(1, 32'h10, 32'h0123_4567, 4'h3, 0, 0, 0, 0, 0, 2'd0, 0);
    do_cmd(0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0);
    for (int n = 0; n < 40; n++) begin
      bit wr = 1'($urandom_range(0, 1));
      bit z = $urandom_range(0, 3) == 0;
      logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
      logic [31:0] d = $urandom;
      logic [3:0] s = 4'($urandom_range(0, 15));
      logic [1:0] rsp = 2'($urandom_range(0, 3));
      bit inj = $urandom_range(0, 3) == 0;
      do_cmd(wr, a, d, s, z ? 0 : $urandom_range(0, 4), z ? 0 : $urandom_range(0, 4),
             z ? 0 : $urandom_range(0, 4), z ? 0 : $urandom_range(0, 4), z ? 0 : $urandom_range(0, 4), rsp, inj);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    check("final_done_low", cmd_done, 0);
    check("final_idle", cmd_idle, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
